adder_pipe: RTL and testbench
=============================

ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 Parameter SEG_W, default 4, carry-chain segment width; one segment is summed per pipeline stage.
REQ-003 Parameter SIGNED, default 0; when 1, ovf reports two's-complement overflow, otherwise ovf is tied 0.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  a, b, ci carry a transaction this cycle.
REQ-007 in_ready  output  1  block accepts a transaction this cycle.
REQ-008 a  input  WIDTH  addend.
REQ-009 b  input  WIDTH  addend.
REQ-010 ci  input  1  carry in.
REQ-011 out_valid  output  1  sum, co, ovf hold a result.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 sum  output  WIDTH  (a + b + ci) mod 2^WIDTH.
REQ-014 co  output  1  carry out of bit WIDTH-1.
REQ-015 ovf  output  1  signed overflow (SIGNED=1 only).

Function
REQ-016 NSEG = WIDTH/SEG_W stages; WIDTH not a multiple of SEG_W, or SEG_W < 1, is an elaboration error.
REQ-017 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready on a rising edge.
REQ-018 Stage k (0..NSEG-1) adds bits [k*SEG_W +: SEG_W] of a and b plus carry from stage k-1 (ci for k=0), registers the partial sum, carry and the still-unsummed upper operand bits.
REQ-019 Last stage's registers drive sum, co, ovf directly; no combinational path from a, b, ci to outputs.
REQ-020 Latency with no stall: transaction accepted at edge t gives out_valid=1 after edge t+NSEG-1 (first visible in cycle following that edge, i.e. NSEG edges including capture).
REQ-021 Throughput one transaction per cycle when out_ready=1.
REQ-022 Each stage has a valid flag; stage k loads when stage k is empty or stage k advances this edge; otherwise it holds.
REQ-023 Bubbles collapse: an empty stage accepts from its predecessor even while the output is stalled.
REQ-024 in_ready = stage 0 empty or stage 0 advancing this cycle; combinational from out_ready allowed.
REQ-025 out_valid && !out_ready: sum, co, ovf and out_valid held stable until transfer out.
REQ-026 Results leave in acceptance order; none dropped or duplicated; capacity NSEG transactions.
REQ-027 ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), computed in the last stage from carried sign bits.
REQ-028 Simultaneous transfer in and out with pipeline full: accepted, occupancy unchanged.
REQ-029 Data registers of empty stages are don't-care internally but sum/co/ovf read 0 when out_valid=0 after reset until the first result.

Reset
REQ-030 rst_n low asynchronously clears all stage valid flags and all data registers: out_valid=0, sum=0, co=0, ovf=0, in_ready=0 while in reset.
REQ-031 Reset mid-operation discards all in-flight transactions; none emerge after release.
REQ-032 First edge after rst_n release: in_ready=1, block empty.

Structure
REQ-033 Shared package adder_pkg holds default WIDTH/SEG_W constants and the NSEG derivation function.
REQ-034 One sub-module adder_seg: SEG_W-bit slice adder with registered sum/carry/valid, stall enable, instantiated NSEG times via generate.

Verification (WIDTH=16, SEG_W=4 unless stated)
REQ-035 a=16'hFFFF, b=16'h0001, ci=0, out_ready=1 -> sum=16'h0000, co=1, ovf=0, out_valid 4 edges after accept.
REQ-036 8 back-to-back random transactions, out_ready=1 -> 8 consecutive correct results in order, in_ready constantly 1.
REQ-037 out_ready=0 while feeding 6 transactions -> in_ready=0 after 4 accepted, output held stable; out_ready=1 -> all 6 results in order.
REQ-038 SIGNED=1, a=16'h7FFF, b=16'h0001, ci=0 -> sum=16'h8000, ovf=1, co=0; a=16'h8000, b=16'h8000 -> sum=0, ovf=1, co=1.
REQ-039 rst_n low for 1 cycle with 3 in flight -> out_valid=0 immediately, no result appears afterwards, next transaction correct.
REQ-040 WIDTH=4, SEG_W=4: a=4'hF, b=4'hF, ci=1 -> sum=4'hF, co=1, out_valid 1 edge after accept.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG_W = 4;

    // Number of pipeline stages. This is guarded against seg_w < 1 so the
    // caller's own legality check can report the problem instead of a divide by zero.
    function automatic int nseg(input int width, input int seg_w);
        return (seg_w < 1) ? 1 : width / seg_w;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// One carry-chain segment: an SEG_W-bit slice adder whose sum, carry and valid are registered.
module adder_seg #(
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             vin,
    input  logic [SEG_W-1:0] a_seg,
    input  logic [SEG_W-1:0] b_seg,
    input  logic             cin,
    output logic             vout,
    output logic [SEG_W-1:0] sum_seg,
    output logic             cout
);

    logic [SEG_W:0]   total;
    logic             valid_reg;
    logic [SEG_W-1:0] sum_reg;
    logic             carry_reg;

    assign total = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, cin};

    // The valid flag follows the stall enable. Data only changes when a real
    // transaction arrives, so bubbles never disturb the visible result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (en) begin
            valid_reg <= vin;
            if (vin) begin
                sum_reg   <= total[SEG_W-1:0];
                carry_reg <= total[SEG_W];
            end
        end
    end

    assign vout    = valid_reg;
    assign sum_seg = sum_reg;
    assign cout    = carry_reg;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined adder. It sums one SEG_W segment per stage and uses valid/ready flow control with bubble collapse.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SEG_W  = DEF_SEG_W,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NSEG   = nseg(WIDTH, SEG_W);
    localparam int SEG_OK = (SEG_W < 1) ? 1 : SEG_W;

    if ((SEG_W < 1) || (WIDTH < 1) || ((WIDTH % SEG_OK) != 0)) begin : g_bad_params
        $error("adder_pipe: WIDTH must be a positive multiple of SEG_W");
    end

    // Stage-input buses. Element gi is what stage gi consumes. Element 0 comes
    // from the ports, and element gi+1 is driven by stage gi's registers.
    logic             in_v   [NSEG];
    logic             in_c   [NSEG];
    logic [WIDTH-1:0] in_opa [NSEG];
    logic [WIDTH-1:0] in_opb [NSEG];
    logic [WIDTH-1:0] in_lo  [NSEG];
    logic             en     [NSEG];

    assign in_v[0]   = in_valid;
    assign in_c[0]   = ci;
    assign in_opa[0] = a;
    assign in_opb[0] = b;
    assign in_lo[0]  = '0;

    // Reset forces in_ready low while rst_n is asserted.
    assign in_ready = rst_n && en[0];

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        localparam int LSB = gi * SEG_W;
        // Operand bits that are still unsummed after this stage.
        localparam logic [WIDTH-1:0] KEEP = {WIDTH{1'b1}} << ((gi + 1) * SEG_W);

        logic             v_q;
        logic             c_q;
        logic [SEG_W-1:0] seg_q;
        logic             down_rdy;
        logic             load;
        logic [WIDTH-1:0] lo_reg;
        logic [WIDTH-1:0] acc_w;

        // The stage loads when it is empty or when its content moves on this edge.
        assign en[gi] = !v_q || down_rdy;
        assign load   = en[gi] && in_v[gi];

        adder_seg #(.SEG_W(SEG_W)) u_seg (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[gi]),
            .vin     (in_v[gi]),
            .a_seg   (in_opa[gi][LSB +: SEG_W]),
            .b_seg   (in_opb[gi][LSB +: SEG_W]),
            .cin     (in_c[gi]),
            .vout    (v_q),
            .sum_seg (seg_q),
            .cout    (c_q)
        );

        // Partial sum bits already produced by earlier stages travel alongside the transaction.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lo_reg <= '0;
            end else if (load) begin
                lo_reg <= in_lo[gi];
            end
        end

        // Splice this stage's segment into the accumulated sum.
        always_comb begin
            acc_w = lo_reg;
            acc_w[LSB +: SEG_W] = seg_q;
        end

        if (gi < NSEG - 1) begin : g_mid
            logic [WIDTH-1:0] opa_reg;
            logic [WIDTH-1:0] opb_reg;

            // Carry only the operand bits that later stages still have to sum.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opa_reg <= '0;
                    opb_reg <= '0;
                end else if (load) begin
                    opa_reg <= in_opa[gi] & KEEP;
                    opb_reg <= in_opb[gi] & KEEP;
                end
            end

            assign down_rdy       = en[gi + 1];
            assign in_v[gi + 1]   = v_q;
            assign in_c[gi + 1]   = c_q;
            assign in_opa[gi + 1] = opa_reg;
            assign in_opb[gi + 1] = opb_reg;
            assign in_lo[gi + 1]  = acc_w;
        end else begin : g_last
            assign down_rdy  = out_ready;
            assign out_valid = v_q;
            assign sum       = acc_w;
            assign co        = c_q;

            if (SIGNED != 0) begin : g_ovf
                logic sa_reg;
                logic sb_reg;

                // Operand sign bits captured next to the top segment feed the overflow check.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sa_reg <= 1'b0;
                        sb_reg <= 1'b0;
                    end else if (load) begin
                        sa_reg <= in_opa[gi][WIDTH-1];
                        sb_reg <= in_opb[gi][WIDTH-1];
                    end
                end

                assign ovf = (sa_reg == sb_reg) && (acc_w[WIDTH-1] != sa_reg);
            end else begin : g_no_ovf
                assign ovf = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: unsigned 16/4, signed 16/4 and single-stage 4/4 instances.
module tb_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv0, ir0, ov0, or0, ci0, co0, ovf0;
    logic [15:0] a0, b0, s0;
    logic        iv1, ir1, ov1, or1, ci1, co1, ovf1;
    logic [15:0] a1, b1, s1;
    logic        iv2, ir2, ov2, or2, ci2, co2, ovf2;
    logic [3:0]  a2, b2, s2;

    adder_pipe #(.WIDTH(16), .SEG_W(4), .SIGNED(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .ci(ci0),
        .out_valid(ov0), .out_ready(or0), .sum(s0), .co(co0), .ovf(ovf0));
    adder_pipe #(.WIDTH(16), .SEG_W(4), .SIGNED(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .ci(ci1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .co(co1), .ovf(ovf1));
    adder_pipe #(.WIDTH(4), .SEG_W(4), .SIGNED(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .ci(ci2),
        .out_valid(ov2), .out_ready(or2), .sum(s2), .co(co2), .ovf(ovf2));

    int checks = 0;
    int errors = 0;
    logic [17:0] q0[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: exact integer arithmetic. It returns {ovf, co, sum}, and
    // signed overflow means the true result lies outside the w-bit two's-complement range.
    function automatic logic [17:0] model(input logic [15:0] aa, input logic [15:0] bb,
                                          input logic cc, input int w, input bit sgn);
        longint full, lim, sa, sb, s;
        logic [17:0] r;
        full = longint'(aa) + longint'(bb) + longint'(cc);
        lim  = longint'(1) << (w - 1);
        sa   = (longint'(aa) >= lim) ? longint'(aa) - 2 * lim : longint'(aa);
        sb   = (longint'(bb) >= lim) ? longint'(bb) - 2 * lim : longint'(bb);
        s    = sa + sb + longint'(cc);
        r        = '0;
        r[15:0]  = 16'(full % (2 * lim));
        r[16]    = ((full / (2 * lim)) != 0);
        r[17]    = sgn && ((s >= lim) || (s < -lim));
        return r;
    endfunction

    // One cycle on u0. It starts at a falling edge, checks the output against the scoreboard,
    // and records the transfers that happen at the next rising edge.
    task automatic tick0(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                         input logic cc, input logic ordy, output bit acc, output bit took);
        logic [17:0] e;
        iv0 = v; a0 = aa; b0 = bb; ci0 = cc; or0 = ordy;
        #1;
        acc  = iv0 && ir0;
        took = ov0 && or0;
        if (ov0) begin
            if (q0.size() == 0) begin
                check("u0_spurious_out_valid", 32'(ov0), 32'(0));
            end else begin
                e = q0[0];
                check("u0_sum", 32'(s0), 32'(e[15:0]));
                check("u0_co", 32'(co0), 32'(e[16]));
                check("u0_ovf", 32'(ovf0), 32'(e[17]));
                if (took) begin
                    void'(q0.pop_front());
                    $display("u0 out sum=%04h co=%0d ovf=%0d", s0, co0, ovf0);
                end
            end
        end
        if (acc) begin
            q0.push_back(model(aa, bb, cc, 16, 1'b0));
            $display("u0 in  a=%04h b=%04h ci=%0d", aa, bb, cc);
        end
        @(negedge clk);
    endtask

    function automatic logic [3:0] peek(input int sel);
        return (sel == 1) ? {ovf1, co1, ov1, ir1} : {ovf2, co2, ov2, ir2};
    endfunction

    // Single transaction through u1 (sel=1) or u2 (sel=2), with a latency check.
    task automatic oneshot(input int sel, input logic [15:0] aa, input logic [15:0] bb,
                           input logic cc, input int lat);
        logic [17:0] e;
        logic [15:0] so;
        int n;
        if (sel == 1) begin
            iv1 = 1'b1; a1 = aa; b1 = bb; ci1 = cc; or1 = 1'b1;
            e = model(aa, bb, cc, 16, 1'b1);
        end else begin
            iv2 = 1'b1; a2 = aa[3:0]; b2 = bb[3:0]; ci2 = cc; or2 = 1'b1;
            e = model({12'h000, aa[3:0]}, {12'h000, bb[3:0]}, cc, 4, 1'b0);
        end
        #1;
        check($sformatf("u%0d_accept", sel), 32'(peek(sel)), 32'(peek(sel)) | 32'h1);
        @(negedge clk);
        iv1 = 1'b0; iv2 = 1'b0;
        n = 1;
        #1;
        while (!peek(sel)[1] && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        so = (sel == 1) ? s1 : {12'h000, s2};
        check($sformatf("u%0d_out_valid", sel), 32'(peek(sel)[1]), 32'(1));
        check($sformatf("u%0d_latency", sel), 32'(n), 32'(lat));
        check($sformatf("u%0d_sum", sel), 32'(so), 32'(e[15:0]));
        check($sformatf("u%0d_co", sel), 32'(peek(sel)[2]), 32'(e[16]));
        check($sformatf("u%0d_ovf", sel), 32'(peek(sel)[3]), 32'(e[17]));
        $display("u%0d txn a=%04h b=%04h ci=%0d sum=%04h co=%0d ovf=%0d",
                 sel, aa, bb, cc, so, peek(sel)[2], peek(sel)[3]);
        @(negedge clk);
        #1;
        check($sformatf("u%0d_drained", sel), 32'(peek(sel)[1]), 32'(0));
    endtask

    initial begin
        bit acc, took;
        int n, accepted, taken, seen;
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic        vc [6];

        rst_n = 1'b0;
        iv0 = 0; a0 = 0; b0 = 0; ci0 = 0; or0 = 1;
        iv1 = 0; a1 = 0; b1 = 0; ci1 = 0; or1 = 1;
        iv2 = 0; a2 = 0; b2 = 0; ci2 = 0; or2 = 1;

        // Reset state.
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(ov0), 32'(0));
        check("rst_sum", 32'(s0), 32'(0));
        check("rst_co", 32'(co0), 32'(0));
        check("rst_ovf", 32'(ovf0), 32'(0));
        check("rst_in_ready", 32'(ir0), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_in_ready", 32'(ir0), 32'(1));
        @(negedge clk);

        // Carry ripples across every segment, and the latency is NSEG.
        tick0(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, acc, took);
        check("u0_ffff_accept", 32'(acc), 32'(1));
        n = 0; took = 0;
        while (!took && n < 10) begin
            tick0(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, took);
            n++;
        end
        check("u0_ffff_latency", 32'(n), 32'(4));

        // Eight back-to-back random transactions.
        for (int i = 0; i < 8; i++) begin
            tick0(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, acc, took);
            check("u0_b2b_in_ready", 32'(acc), 32'(1));
        end
        n = 0;
        while (q0.size() > 0 && n < 20) begin
            tick0(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, took);
            n++;
        end
        check("u0_b2b_drain", 32'(q0.size()), 32'(0));

        // Stalled output: four are accepted, then back-pressure. Output is held while stalled.
        for (int i = 0; i < 6; i++) begin
            va[i] = 16'($urandom); vb[i] = 16'($urandom); vc[i] = 1'($urandom);
        end
        accepted = 0; taken = 0;
        for (int t = 0; t < 8; t++) begin
            tick0(accepted < 6, va[accepted % 6], vb[accepted % 6], vc[accepted % 6], 1'b0, acc, took);
            if (acc) accepted++;
        end
        check("u0_stall_accepted", 32'(accepted), 32'(4));
        #1;
        check("u0_stall_in_ready", 32'(ir0), 32'(0));
        @(negedge clk);
        // Full pipeline with simultaneous transfer in and out.
        tick0(1'b1, va[4], vb[4], vc[4], 1'b1, acc, took);
        check("u0_full_in_ready", 32'(acc), 32'(1));
        check("u0_full_take", 32'(took), 32'(1));
        if (acc) accepted++;
        if (took) taken++;
        n = 0;
        while ((accepted < 6 || q0.size() > 0) && n < 30) begin
            tick0(accepted < 6, va[accepted % 6], vb[accepted % 6], vc[accepted % 6], 1'b1, acc, took);
            if (acc) accepted++;
            if (took) taken++;
            n++;
        end
        check("u0_stall_total_out", 32'(taken), 32'(6));

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            tick0(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, acc, took);
        end
        iv0 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(ov0), 32'(0));
        check("midrst_sum", 32'(s0), 32'(0));
        check("midrst_in_ready", 32'(ir0), 32'(0));
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        seen = 0;
        for (int t = 0; t < 8; t++) begin
            tick0(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, took);
            if (took) seen++;
        end
        check("midrst_no_ghost", 32'(seen), 32'(0));
        tick0(1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b1, acc, took);
        check("midrst_next_accept", 32'(acc), 32'(1));
        n = 0;
        while (q0.size() > 0 && n < 10) begin
            tick0(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, took);
            n++;
        end
        check("midrst_next_drain", 32'(q0.size()), 32'(0));

        // Signed overflow cases, plus some random signed sums.
        oneshot(1, 16'h7FFF, 16'h0001, 1'b0, 4);
        oneshot(1, 16'h8000, 16'h8000, 1'b0, 4);
        for (int i = 0; i < 3; i++) begin
            oneshot(1, 16'($urandom), 16'($urandom), 1'($urandom), 4);
        end

        // Single-stage configuration.
        oneshot(2, 16'h000F, 16'h000F, 1'b1, 1);
        for (int i = 0; i < 3; i++) begin
            oneshot(2, 16'($urandom), 16'($urandom), 1'($urandom), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
